// File: rtl/lcd_pkg.sv
// Shared types and helpers for the character-LCD write engine.
//   lcd_state_e  : engine state encoding
//   LCD_CMD_*    : instruction codes that need the long execution wait
//   is_long_cmd  : classifies a request as clear/home (long wait) or not
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_EN_HI,
    ST_EN_LO,
    ST_EXEC
  } lcd_state_e;

  localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
  localparam logic [7:0] LCD_CMD_HOME  = 8'h02;

  // Clear (0x01) and home (0x02/0x03) are the only instructions whose upper
  // six bits are zero with a non-zero low pair; bit 0 of home is don't-care.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    logic [7:0] long_mask;
    long_mask   = LCD_CMD_CLEAR | LCD_CMD_HOME;
    is_long_cmd = !rs && ((data & ~long_mask) == 8'h00) && ((data & long_mask) != 8'h00);
  endfunction

endpackage

// File: rtl/lcd_delay_counter.sv
// Loadable down-counter used to time each engine state.
//   clk_i   : clock
//   rst_ni  : synchronous active-low reset (clears the count)
//   load_i  : load value_i this cycle (takes priority over counting)
//   value_i : value to load (state length minus one)
//   zero_o  : count is zero; the owning state ends on this cycle
// The count saturates at zero so an idle counter never wraps.
module lcd_delay_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = value_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/lcd_write_engine.sv
// HD44780-class character-LCD bus write engine.
// Turns one byte request into timed RS/DATA/E bus cycles (8-bit or 4-bit bus)
// and then waits out the controller execution time before going idle.
//   iClk, nRst        : clock, synchronous active-low reset
//   iValid/oReady     : request handshake (accepted when both are high)
//   iData, iRS        : byte to write, register select (1 = data)
//   oDone             : one-cycle pulse when the request and its wait finish
//   LCD_DATA/RS/RW/En : registered LCD pins (RW tied low)
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | ready for a request, bus holds the last written value
// ST_SETUP | RS/DATA stable before E rises (SETUP_CYC)
// ST_EN_HI | E high pulse (EN_HIGH_CYC)
// ST_EN_LO | E low, hold plus minimum cycle (EN_LOW_CYC)
// ST_EXEC  | controller execution wait (EXEC_CYC or LONG_EXEC_CYC)
module lcd_write_engine
  import lcd_pkg::*;
#(
  parameter int unsigned SETUP_CYC     = 2,
  parameter int unsigned EN_HIGH_CYC   = 16,
  parameter int unsigned EN_LOW_CYC    = 16,
  parameter int unsigned EXEC_CYC      = 2000,
  parameter int unsigned LONG_EXEC_CYC = 80000,
  parameter bit          BUS_4BIT      = 1'b0
) (
  input  logic       iClk,
  input  logic       nRst,
  input  logic       iValid,
  output logic       oReady,
  input  logic [7:0] iData,
  input  logic       iRS,
  output logic       oDone,
  output logic [7:0] LCD_DATA,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_En
);

  localparam int unsigned CW = $clog2(LONG_EXEC_CYC + 1);

  // Counter is loaded with N-1 on entry so each state lasts exactly N cycles.
  localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] EN_HI_LD = CW'(EN_HIGH_CYC - 1);
  localparam logic [CW-1:0] EN_LO_LD = CW'(EN_LOW_CYC - 1);
  localparam logic [CW-1:0] EXEC_LD  = CW'(EXEC_CYC - 1);
  localparam logic [CW-1:0] LONG_LD  = CW'(LONG_EXEC_CYC - 1);

  lcd_state_e    state_q, state_d;
  logic [7:0]    data_q, data_d;
  logic [7:0]    bus_q, bus_d;
  logic          rs_q, rs_d;
  logic          long_q, long_d;
  logic          nib_q, nib_d;
  logic          en_q, en_d;
  logic          ready_q, ready_d;
  logic          done_q, done_d;
  logic          cnt_load;
  logic [CW-1:0] cnt_val;
  logic          cnt_zero;

  lcd_delay_counter #(
    .W (CW)
  ) u_delay (
    .clk_i   (iClk),
    .rst_ni  (nRst),
    .load_i  (cnt_load),
    .value_i (cnt_val),
    .zero_o  (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    bus_d    = bus_q;
    rs_d     = rs_q;
    long_d   = long_q;
    nib_d    = nib_q;
    en_d     = en_q;
    ready_d  = ready_q;
    done_d   = 1'b0;
    cnt_load = 1'b0;
    cnt_val  = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (iValid && ready_q) begin
          data_d   = iData;
          rs_d     = iRS;
          long_d   = is_long_cmd(iRS, iData);
          nib_d    = 1'b0;
          // 4-bit bus: high nibble goes first on DATA[7:4], DATA[3:0] held low.
          bus_d    = BUS_4BIT ? {iData[7:4], 4'h0} : iData;
          ready_d  = 1'b0;
          state_d  = ST_SETUP;
          cnt_load = 1'b1;
          cnt_val  = SETUP_LD;
        end
      end
      ST_SETUP: begin
        if (cnt_zero) begin
          en_d     = 1'b1;
          state_d  = ST_EN_HI;
          cnt_load = 1'b1;
          cnt_val  = EN_HI_LD;
        end
      end
      ST_EN_HI: begin
        if (cnt_zero) begin
          en_d     = 1'b0;
          state_d  = ST_EN_LO;
          cnt_load = 1'b1;
          cnt_val  = EN_LO_LD;
        end
      end
      ST_EN_LO: begin
        if (cnt_zero) begin
          cnt_load = 1'b1;
          if (BUS_4BIT && !nib_q) begin
            nib_d   = 1'b1;
            bus_d   = {data_q[3:0], 4'h0};
            state_d = ST_SETUP;
            cnt_val = SETUP_LD;
          end else begin
            state_d = ST_EXEC;
            cnt_val = long_q ? LONG_LD : EXEC_LD;
          end
        end
      end
      ST_EXEC: begin
        if (cnt_zero) begin
          done_d  = 1'b1;
          ready_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        en_d    = 1'b0;
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge iClk) begin
    if (!nRst) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      bus_q   <= '0;
      rs_q    <= 1'b0;
      long_q  <= 1'b0;
      nib_q   <= 1'b0;
      en_q    <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      bus_q   <= bus_d;
      rs_q    <= rs_d;
      long_q  <= long_d;
      nib_q   <= nib_d;
      en_q    <= en_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign oReady   = ready_q;
  assign oDone    = done_q;
  assign LCD_DATA = bus_q;
  assign LCD_RS   = rs_q;
  assign LCD_RW   = 1'b0;
  assign LCD_En   = en_q;

endmodule
